fv_sb_hs_monitor: RTL and testbench

Upstream adapter/checker that sits between a valid/ready DUT and the in-order formal scoreboard.
- Observes the DUT ingress and egress valid/ready channels.
- Converts completed handshakes into the scoreboard's push_valid/push_data and pop_valid/pop_data event streams.
- Tracks outstanding transactions and flags protocol violations (payload instability, underflow, overflow, stall timeout) as sticky, synthesizable error outputs, usable in simulation and in formal runs.

---
 rtl/fv_sb_pkg.sv | 15 +
 rtl/fv_sb_hs_chan_chk.sv | 81 ++++++++
 rtl/fv_sb_hs_monitor.sv | 130 +++++++++++++
 tb/tb_fv_sb_hs_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fv_sb_pkg.sv
// ---------------------------------------------------------------------------
// fv_sb_pkg
//   Shared types for the scoreboard handshake monitor.
//   hs_state_e : per-channel valid/ready tracking state
//     HS_IDLE  - no offer is pending
//     HS_STALL - valid is held without ready; payload is being watched
// ---------------------------------------------------------------------------
package fv_sb_pkg;

   typedef enum logic {
      HS_IDLE  = 1'b0,
      HS_STALL = 1'b1
   } hs_state_e;

endpackage : fv_sb_pkg

// File: rtl/fv_sb_hs_chan_chk.sv
// ---------------------------------------------------------------------------
// fv_sb_hs_chan_chk
//   Watches one valid/ready channel.  Reports the handshake and flags the
//   cycle in which the channel breaks the hold-while-stalled rule or has
//   been stalled for MAX_STALL cycles.  The error outputs are single-cycle
//   indications; the parent makes them sticky.
//
// Ports
//   clk          : clock
//   rstn         : asynchronous active-low reset
//   valid_i      : channel valid
//   ready_i      : channel ready
//   data_i       : channel payload
//   fire_o       : valid && ready this cycle
//   stable_err_o : stalled offer withdrawn or payload changed this cycle
//   stall_err_o  : stalled MAX_STALL cycles and still not ready
// ---------------------------------------------------------------------------
module fv_sb_hs_chan_chk #(
   parameter int DWIDTH    = 4,
   parameter int MAX_STALL = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              valid_i,
   input  logic              ready_i,
   input  logic [DWIDTH-1:0] data_i,
   output logic              fire_o,
   output logic              stable_err_o,
   output logic              stall_err_o
);

   import fv_sb_pkg::*;

   localparam int CW = $clog2(MAX_STALL + 1);

   hs_state_e         state_q;
   logic [CW-1:0]     stall_cnt_q;
   logic [DWIDTH-1:0] hold_data_q;

   assign fire_o       = valid_i && ready_i;
   assign stable_err_o = (state_q == HS_STALL) && (!valid_i || (data_i != hold_data_q));
   assign stall_err_o  = (state_q == HS_STALL) && !ready_i &&
                         (stall_cnt_q == CW'(MAX_STALL));

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= HS_IDLE;
         stall_cnt_q <= '0;
      end else begin
         case (state_q)
            HS_IDLE: begin
               if (valid_i && !ready_i) begin
                  state_q     <= HS_STALL;
                  stall_cnt_q <= CW'(1);
               end
            end
            HS_STALL: begin
               // Handshake or withdrawn offer both end the stall; a changed
               // payload alone does not.
               if (!valid_i || ready_i) begin
                  state_q <= HS_IDLE;
               end else if (stall_cnt_q != CW'(MAX_STALL)) begin
                  stall_cnt_q <= stall_cnt_q + CW'(1);
               end
            end
            default: state_q <= HS_IDLE;
         endcase
      end
   end

   // NOTE: the hold register has no reset; it is only compared while in
   // HS_STALL, and entering HS_STALL always loads it first.
   always_ff @(posedge clk) begin
      if ((state_q == HS_IDLE) && valid_i && !ready_i) begin
         hold_data_q <= data_i;
      end
   end

endmodule : fv_sb_hs_chan_chk

// File: rtl/fv_sb_hs_monitor.sv
// ---------------------------------------------------------------------------
// fv_sb_hs_monitor
//   Adapter between a valid/ready DUT and the in-order scoreboard.  Turns
//   ingress/egress handshakes into push/pop events, counts transactions in
//   flight and latches protocol violations as sticky error flags.
//
// Ports
//   clk, rstn                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      : DUT ingress channel (observed)
//   out_valid/out_ready/out_data   : DUT egress channel (observed)
//   push_valid/push_data           : ingress handshake event (combinational)
//   pop_valid/pop_data             : egress handshake event (combinational)
//   outstanding                    : accepted but not yet emitted
//   err_in_stable/err_out_stable   : sticky payload/valid instability
//   err_underflow/err_overflow     : sticky counter violations
//   err_stall                      : sticky stall timeout, either channel
//   err_any                        : OR of all sticky flags
// ---------------------------------------------------------------------------
module fv_sb_hs_monitor #(
   parameter int DWIDTH    = 4,
   parameter int MAX_TRANS = 16,
   parameter int MAX_STALL = 8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           in_valid,
   input  logic                           in_ready,
   input  logic [DWIDTH-1:0]              in_data,
   input  logic                           out_valid,
   input  logic                           out_ready,
   input  logic [DWIDTH-1:0]              out_data,
   output logic                           push_valid,
   output logic [DWIDTH-1:0]              push_data,
   output logic                           pop_valid,
   output logic [DWIDTH-1:0]              pop_data,
   output logic [$clog2(MAX_TRANS):0]     outstanding,
   output logic                           err_in_stable,
   output logic                           err_out_stable,
   output logic                           err_underflow,
   output logic                           err_overflow,
   output logic                           err_stall,
   output logic                           err_any
);

   import fv_sb_pkg::*;

   localparam int OW = $clog2(MAX_TRANS) + 1;

   logic          in_stable_ev, in_stall_ev;
   logic          out_stable_ev, out_stall_ev;
   logic          underflow_ev, overflow_ev;
   logic [OW-1:0] outstanding_q, outstanding_d;

   logic err_in_stable_q, err_out_stable_q, err_underflow_q;
   logic err_overflow_q, err_stall_q;

   fv_sb_hs_chan_chk #(.DWIDTH(DWIDTH), .MAX_STALL(MAX_STALL)) u_in_chk (
      .clk          (clk),
      .rstn         (rstn),
      .valid_i      (in_valid),
      .ready_i      (in_ready),
      .data_i       (in_data),
      .fire_o       (push_valid),
      .stable_err_o (in_stable_ev),
      .stall_err_o  (in_stall_ev)
   );

   fv_sb_hs_chan_chk #(.DWIDTH(DWIDTH), .MAX_STALL(MAX_STALL)) u_out_chk (
      .clk          (clk),
      .rstn         (rstn),
      .valid_i      (out_valid),
      .ready_i      (out_ready),
      .data_i       (out_data),
      .fire_o       (pop_valid),
      .stable_err_o (out_stable_ev),
      .stall_err_o  (out_stall_ev)
   );

   assign push_data = in_data;
   assign pop_data  = out_data;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      outstanding_d = outstanding_q;
      underflow_ev  = 1'b0;
      overflow_ev   = 1'b0;
      // Push and pop together leave the count alone at any level,
      // including empty (cut-through) and full.
      case ({push_valid, pop_valid})
         2'b10: begin
            if (outstanding_q == OW'(MAX_TRANS)) overflow_ev = 1'b1;
            else                                 outstanding_d = outstanding_q + OW'(1);
         end
         2'b01: begin
            if (outstanding_q == '0) underflow_ev = 1'b1;
            else                     outstanding_d = outstanding_q - OW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_q    <= '0;
         err_in_stable_q  <= 1'b0;
         err_out_stable_q <= 1'b0;
         err_underflow_q  <= 1'b0;
         err_overflow_q   <= 1'b0;
         err_stall_q      <= 1'b0;
      end else begin
         outstanding_q    <= outstanding_d;
         err_in_stable_q  <= err_in_stable_q  | in_stable_ev;
         err_out_stable_q <= err_out_stable_q | out_stable_ev;
         err_underflow_q  <= err_underflow_q  | underflow_ev;
         err_overflow_q   <= err_overflow_q   | overflow_ev;
         err_stall_q      <= err_stall_q      | in_stall_ev | out_stall_ev;
      end
   end

   assign outstanding    = outstanding_q;
   assign err_in_stable  = err_in_stable_q;
   assign err_out_stable = err_out_stable_q;
   assign err_underflow  = err_underflow_q;
   assign err_overflow   = err_overflow_q;
   assign err_stall      = err_stall_q;
   assign err_any        = err_in_stable_q | err_out_stable_q | err_underflow_q |
                           err_overflow_q | err_stall_q;

endmodule : fv_sb_hs_monitor

// File: tb/tb_fv_sb_hs_monitor.sv
// ---------------------------------------------------------------------------
// tb_fv_sb_hs_monitor
//   Directed scenarios followed by randomized traffic, all compared every
//   cycle against a reference model built from the channel rules: a channel
//   is "stalled" for as many consecutive cycles as it offered without being
//   accepted, and the payload offered on the first of those cycles must be
//   held for the rest of the run.
// ---------------------------------------------------------------------------
module tb_fv_sb_hs_monitor;

   localparam int DW  = 4;
   localparam int MT  = 16;
   localparam int MS  = 8;
   localparam int OW  = $clog2(MT) + 1;

   logic          clk;
   logic          rstn;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic          push_valid, pop_valid;
   logic [DW-1:0] push_data, pop_data;
   logic [OW-1:0] outstanding;
   logic          err_in_stable, err_out_stable, err_underflow;
   logic          err_overflow, err_stall, err_any;

   fv_sb_hs_monitor #(.DWIDTH(DW), .MAX_TRANS(MT), .MAX_STALL(MS)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .push_valid     (push_valid),
      .push_data      (push_data),
      .pop_valid      (pop_valid),
      .pop_data       (pop_data),
      .outstanding    (outstanding),
      .err_in_stable  (err_in_stable),
      .err_out_stable (err_out_stable),
      .err_underflow  (err_underflow),
      .err_overflow   (err_overflow),
      .err_stall      (err_stall),
      .err_any        (err_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int            run_i, run_o;         // consecutive offered-not-accepted cycles
   logic [DW-1:0] start_i, start_o;     // payload at the start of that run
   int            m_out;
   logic          m_is, m_os, m_unf, m_ovf, m_st;

   task automatic model_reset();
      run_i = 0; run_o = 0; m_out = 0;
      m_is = 0; m_os = 0; m_unf = 0; m_ovf = 0; m_st = 0;
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_update();
      bit ps, pp;
      if (!rstn) begin
         model_reset();
         return;
      end
      ps = in_valid && in_ready;
      pp = out_valid && out_ready;
      if (run_i > 0 && (!in_valid || in_data != start_i))   m_is = 1;
      if (run_o > 0 && (!out_valid || out_data != start_o)) m_os = 1;
      if ((run_i >= MS && !in_ready) || (run_o >= MS && !out_ready)) m_st = 1;
      if (ps && !pp) begin
         if (m_out == MT) m_ovf = 1;
         else             m_out = m_out + 1;
      end else if (pp && !ps) begin
         if (m_out == 0) m_unf = 1;
         else            m_out = m_out - 1;
      end
      if (in_valid && !in_ready) begin
         if (run_i == 0) start_i = in_data;
         run_i++;
      end else run_i = 0;
      if (out_valid && !out_ready) begin
         if (run_o == 0) start_o = out_data;
         run_o++;
      end else run_o = 0;
   endtask

   task automatic check_all();
      check("push_valid", 32'(push_valid), 32'(in_valid && in_ready));
      check("push_data",  32'(push_data),  32'(in_data));
      check("pop_valid",  32'(pop_valid),  32'(out_valid && out_ready));
      check("pop_data",   32'(pop_data),   32'(out_data));
      check("outstanding", 32'(outstanding), 32'(m_out));
      check("err_vec",
            32'({err_in_stable, err_out_stable, err_underflow, err_overflow, err_stall}),
            32'({m_is, m_os, m_unf, m_ovf, m_st}));
      check("err_any", 32'(err_any), 32'(m_is | m_os | m_unf | m_ovf | m_st));
   endtask

   // One clock: drive just after the rising edge, check at the falling edge,
   // then advance the model to the next rising edge.
   task automatic step(input logic r, input logic iv, input logic ir, input logic [DW-1:0] id,
                       input logic ov, input logic orr, input logic [DW-1:0] od);
      @(posedge clk);
      #1;
      rstn = r; in_valid = iv; in_ready = ir; in_data = id;
      out_valid = ov; out_ready = orr; out_data = od;
      @(negedge clk);
      if (!rstn) model_reset();
      check_all();
      model_update();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, '0, 0, 0, '0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, '0, 0, 0, '0);
      step(0, 0, 0, '0, 0, 0, '0);
      idle(1);
   endtask

   initial begin
      rstn = 1'b0;
      in_valid = 0; in_ready = 0; in_data = '0;
      out_valid = 0; out_ready = 0; out_data = '0;
      model_reset();

      // 1: three pushes then three pops
      do_reset();
      for (int k = 1; k <= 3; k++) step(1, 1, 1, DW'(k), 0, 0, '0);
      for (int k = 1; k <= 3; k++) step(1, 0, 0, '0, 1, 1, DW'(k));
      idle(1);
      check("t1_outstanding", 32'(outstanding), 32'd0);
      check("t1_err_any", 32'(err_any), 32'd0);

      // 2: ingress payload changes while stalled
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 1, 0, 4'd5, 0, 0, '0);
      step(1, 1, 0, 4'd6, 0, 0, '0);
      step(1, 1, 1, 4'd6, 0, 0, '0);
      idle(2);
      check("t2_err_in_stable", 32'(err_in_stable), 32'd1);

      // 3: pop with nothing outstanding
      do_reset();
      step(1, 0, 0, '0, 1, 1, 4'd9);
      idle(1);
      check("t3_err_underflow", 32'(err_underflow), 32'd1);
      check("t3_outstanding", 32'(outstanding), 32'd0);

      // 4: fill to MAX_TRANS, lone push overflows, push+pop at full holds
      do_reset();
      for (int k = 0; k < MT; k++) step(1, 1, 1, DW'(k), 0, 0, '0);
      step(1, 1, 1, 4'hf, 0, 0, '0);
      step(1, 1, 1, 4'h3, 1, 1, 4'h0);
      idle(1);
      check("t4_outstanding", 32'(outstanding), 32'(MT));
      check("t4_err_overflow", 32'(err_overflow), 32'd1);

      // 5: egress stall timeout, then the pop completes
      for (int k = 0; k < MS + 2; k++) step(1, 0, 0, '0, 1, 0, 4'ha);
      step(1, 0, 0, '0, 1, 1, 4'ha);
      idle(1);
      check("t5_err_stall", 32'(err_stall), 32'd1);
      check("t5_outstanding", 32'(outstanding), 32'(MT - 1));

      // 6: asynchronous reset in the middle of an ingress stall
      for (int k = 0; k < 3; k++) step(1, 1, 0, 4'h7, 0, 0, '0);
      #2 rstn = 1'b0;
      #1 model_reset();
      check_all();
      check("t6_err_any_async", 32'(err_any), 32'd0);
      step(0, 1, 0, 4'h7, 0, 0, '0);
      step(1, 1, 1, 4'h4, 0, 0, '0);
      idle(1);
      check("t6_outstanding", 32'(outstanding), 32'd1);
      check("t6_err_any", 32'(err_any), 32'd0);

      // Randomized traffic: mostly protocol-abiding, rare violations,
      // occasional resets so the sticky flags do not saturate.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         logic r, iv, ir, ov, orr;
         logic [DW-1:0] id, od;
         r = ($urandom_range(119) != 0);
         if (run_i > 0) begin
            iv = ($urandom_range(39) != 0);
            id = ($urandom_range(39) == 0) ? DW'($urandom) : start_i;
            ir = ($urandom_range(3) == 0);
         end else begin
            iv = 1'($urandom);
            id = DW'($urandom);
            ir = 1'($urandom);
         end
         if (run_o > 0) begin
            ov  = ($urandom_range(39) != 0);
            od  = ($urandom_range(39) == 0) ? DW'($urandom) : start_o;
            orr = ($urandom_range(3) == 0);
         end else begin
            ov  = (m_out > 0) ? 1'($urandom) : ($urandom_range(15) == 0);
            od  = DW'($urandom);
            orr = 1'($urandom);
         end
         step(r, iv, ir, id, ov, orr, od);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fv_sb_hs_monitor
